fp_result_buffer: RTL and testbench

FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

---
 rtl/fp_result_buffer.sv | 109 ++++++++++
 tb/tb_fp_result_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_buffer.sv
// FIFO of ALU results with sticky exception flags and a saturating exception counter.
// Latency 1 (no bypass); in_ready drops when full, a full buffer refuses pushes even while popping.
module fp_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [3:0]       in_op,
    input  logic             in_exception,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_op,
    output logic [2:0]       out_flags,
    output logic [2:0]       sticky_flags,
    input  logic             sticky_clear,
    output logic [CNT_W-1:0] exc_count,
    output logic [LW-1:0]    level
);

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  op;
        logic [2:0]  flags;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    entry_t           in_entry;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [2:0]       in_flags;
    logic [CNT_W-1:0] cnt_base;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign in_ready  = (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_flags  = {in_exception, in_overflow, in_underflow};
    assign in_entry  = '{result: in_result, op: in_op, flags: in_flags};
    assign head      = mem[rd_ptr];

    // Stale storage is never exposed: data outputs are forced to zero while empty.
    assign out_result = out_valid ? head.result : '0;
    assign out_op     = out_valid ? head.op     : '0;
    assign out_flags  = out_valid ? head.flags  : '0;

    assign cnt_base = sticky_clear ? '0 : exc_count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Events arriving in the clear cycle survive the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_flags <= '0;
            exc_count    <= '0;
        end else begin
            if (push) begin
                sticky_flags <= (sticky_clear ? 3'b000 : sticky_flags) | in_flags;
            end else if (sticky_clear) begin
                sticky_flags <= '0;
            end
            if (push && in_exception) begin
                exc_count <= (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
            end else if (sticky_clear) begin
                exc_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Scoreboard bench for fp_result_buffer: queue model of accepted results plus directed flag/counter checks.
module tb_fp_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [3:0]       in_op;
    logic             in_exception;
    logic             in_overflow;
    logic             in_underflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_op;
    logic [2:0]       out_flags;
    logic [2:0]       sticky_flags;
    logic             sticky_clear;
    logic [CNT_W-1:0] exc_count;
    logic [2:0]       level;

    int n_cmp = 0;
    int n_err = 0;
    logic [38:0] exp_q [$];

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_op        (in_op),
        .in_exception (in_exception),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clear (sticky_clear),
        .exc_count    (exc_count),
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pop head then accept push, sampled mid-cycle.
    always @(negedge clk) begin
        logic will_push;
        logic [38:0] head;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            will_push = in_valid && (exp_q.size() < DEPTH);
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_ready && exp_q.size() != 0) begin
                head = exp_q.pop_front();
                chk("head_entry", {25'b0, out_result, out_op, out_flags}, 64'(head));
            end
            if (will_push) begin
                exp_q.push_back({in_result, in_op, in_exception, in_overflow, in_underflow});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0;
        in_exception = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0;
        out_ready = 1'b0; sticky_clear = 1'b0;
        step(); step();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_sticky", 64'(sticky_flags), 64'd0);
        chk("rst_exc_count", 64'(exc_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Single push, visible one cycle later
        in_valid = 1'b1; in_result = 32'h420151EC; in_op = 4'd0;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_result", 64'(out_result), 64'h420151EC);
        chk("t1_out_op", 64'(out_op), 64'd0);
        chk("t1_level", 64'(level), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_empty", 64'(level), 64'd0);

        // Fill to full, refuse fifth push, drain in order
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op = 4'(i); in_result = 32'h3F800000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t2_level_full", 64'(level), 64'd4);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_op", 64'(out_op), 64'(i));
            step();
        end
        chk("t2_drained", 64'(out_valid), 64'd0);
        chk("t2_zero_result", 64'(out_result), 64'd0);
        chk("t2_zero_op", 64'(out_op), 64'd0);

        // Full with simultaneous push/pop: pop only; then steady level 2 with wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 4'(5 + i); in_result = 32'hC0000000 + 32'(i);
            step();
        end
        in_op = 4'd9; in_result = 32'hDEADBEEF; out_ready = 1'b1;
        step();
        chk("t3_pop_only", 64'(level), 64'd3);
        in_valid = 1'b0;
        step();
        chk("t3_level2", 64'(level), 64'd2);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_op = 4'(i); in_result = $urandom;
            step();
            chk("t3_steady_level", 64'(level), 64'd2);
        end
        in_valid = 1'b0;
        step(); step();
        chk("t3_empty", 64'(level), 64'd0);

        // Sticky flags and exception counter with clear interactions
        in_valid = 1'b1; in_result = 32'h7F800000; in_op = 4'd2;
        in_exception = 1'b1; in_overflow = 1'b1;
        step();
        in_exception = 1'b0; in_overflow = 1'b0;
        step();
        in_valid = 1'b0;
        chk("t4_sticky", 64'(sticky_flags), 64'b110);
        chk("t4_exc", 64'(exc_count), 64'd1);
        in_valid = 1'b1; in_underflow = 1'b1; sticky_clear = 1'b1;
        step();
        in_valid = 1'b0; in_underflow = 1'b0; sticky_clear = 1'b0;
        chk("t4_clr_sticky", 64'(sticky_flags), 64'b001);
        chk("t4_clr_exc", 64'(exc_count), 64'd0);
        in_valid = 1'b1; in_exception = 1'b1; sticky_clear = 1'b1;
        step();
        in_valid = 1'b0; in_exception = 1'b0;
        chk("t4_clr_exc_push", 64'(exc_count), 64'd1);
        chk("t4_clr_sticky_push", 64'(sticky_flags), 64'b100);
        step();
        sticky_clear = 1'b0;
        chk("t4_clr_only_sticky", 64'(sticky_flags), 64'd0);
        chk("t4_clr_only_exc", 64'(exc_count), 64'd0);

        // Counter saturation
        in_valid = 1'b1; in_exception = 1'b1;
        for (int i = 1; i <= 258; i++) begin
            in_result = 32'(i); in_op = 4'(i);
            step();
            if (i == 254) chk("t5_exc_254", 64'(exc_count), 64'd254);
            if (i == 256) chk("t5_exc_sat", 64'(exc_count), 64'd255);
        end
        in_valid = 1'b0; in_exception = 1'b0;
        chk("t5_exc_hold", 64'(exc_count), 64'd255);
        step(); step();

        // Reset mid-operation discards entries and the coincident push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_overflow = 1'b1; in_op = 4'(i); in_result = 32'h1000 + 32'(i);
            step();
        end
        chk("t6_level3", 64'(level), 64'd3);
        in_op = 4'hF; rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0; in_overflow = 1'b0;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_sticky", 64'(sticky_flags), 64'd0);
        chk("t6_exc", 64'(exc_count), 64'd0);
        step();
        chk("t6_no_late_push", 64'(level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
